shift_sequencer: RTL and testbench

Multi-cycle front end for the single-position shift unit. It accepts an operand, a shift amount, a mode (arithmetic / rotate / logical) and a direction over a valid/ready handshake. It then applies the one-bit shift repeatedly, once per clock, until the requested amount is reached. The result is presented to the downstream ALU result mux on a valid/ready output handshake.

---
 rtl/shift_sequencer.sv | 159 +++++++++++++++
 tb/tb_shift_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: accepts one request, applies a single-position
// shift once per clock until the requested amount is reached, then holds the result.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] b,
  input  logic [AMT_W-1:0] amt,
  input  logic             A,
  input  logic             R,
  input  logic             L,
  input  logic             drxn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_LOG = 2'd0,
    MODE_ARI = 2'd1,
    MODE_ROT = 2'd2
  } mode_t;

  state_t           state_r;
  mode_t            mode_r;
  logic [WIDTH-1:0] data_r;
  logic [AMT_W-1:0] cnt_r;
  logic             drxn_r;
  logic             err_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             bad_mode_s;
  mode_t            mode_s;

  function automatic logic onehot3(input logic [2:0] v);
    logic oh;
    case (v)
      3'b100:  oh = 1'b1;
      3'b010:  oh = 1'b1;
      3'b001:  oh = 1'b1;
      default: oh = 1'b0;
    endcase
    return oh;
  endfunction

  // A bad mode never shifts, so its encoding only has to be some legal value.
  function automatic mode_t encode_mode(input logic a_i, input logic r_i);
    mode_t m;
    if (a_i) begin
      m = MODE_ARI;
    end else if (r_i) begin
      m = MODE_ROT;
    end else begin
      m = MODE_LOG;
    end
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] d,
                                              input mode_t m,
                                              input logic right);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_LOG: r = right ? {1'b0, d[WIDTH-1:1]}       : {d[WIDTH-2:0], 1'b0};
      MODE_ARI: r = right ? {d[WIDTH-1], d[WIDTH-1:1]} : {d[WIDTH-2:0], 1'b0};
      MODE_ROT: r = right ? {d[0], d[WIDTH-1:1]}       : {d[WIDTH-2:0], d[WIDTH-1]};
      default:  r = d;
    endcase
    return r;
  endfunction

  // Request decode, sampled only at the accepting edge.
  always_comb begin
    bad_mode_s = ~onehot3({A, R, L});
    mode_s     = encode_mode(A, R);
  end

  // Sequencer state, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mode_r      <= MODE_LOG;
      data_r      <= '0;
      cnt_r       <= '0;
      drxn_r      <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r <= b;
            cnt_r  <= amt;
            mode_r <= mode_s;
            drxn_r <= drxn;
            err_r  <= bad_mode_s;
            busy_r <= 1'b1;
            if (bad_mode_s || (amt == '0)) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= SHIFT;
              out_valid_r <= 1'b0;
            end
          end else begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
          end
        end
        SHIFT: begin
          data_r <= shift1(data_r, mode_r, drxn_r);
          cnt_r  <= cnt_r - AMT_W'(1);
          busy_r <= 1'b1;
          if (cnt_r == AMT_W'(1)) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE) & ~rst;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign B         = data_r;
  assign err       = err_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed plus a few random requests; expected results are queued at acceptance
// and compared when the sequencer reports out_valid.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] b = 32'd0;
  logic [4:0]  amt = 5'd0;
  logic        A = 1'b0;
  logic        R = 1'b0;
  logic        L = 1'b0;
  logic        drxn = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] B;
  logic        err;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .b(b), .amt(amt), .A(A), .R(R), .L(L), .drxn(drxn),
    .out_valid(out_valid), .out_ready(out_ready), .B(B), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Whole-amount reference: rotates via a doubled word, arithmetic via a signed shift.
  function automatic logic [31:0] model(input logic [31:0] v, input logic [4:0] n,
                                        input logic a_i, input logic r_i, input logic d_i);
    logic [63:0]        dd;
    logic signed [31:0] sv;
    logic [31:0]        res;
    dd = {v, v};
    sv = v;
    if (r_i && d_i) begin
      dd  = dd >> n;
      res = dd[31:0];
    end else if (r_i) begin
      dd  = dd << n;
      res = dd[63:32];
    end else if (a_i && d_i) begin
      res = sv >>> n;
    end else if (d_i) begin
      res = v >> n;
    end else begin
      res = v << n;
    end
    return res;
  endfunction

  task automatic send(input logic [31:0] vb, input logic [4:0] va, input logic a_i,
                      input logic r_i, input logic l_i, input logic d_i,
                      input logic [31:0] eb, input logic ee);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_send", {63'd0, in_ready}, 64'd1);
    b = vb; amt = va; A = a_i; R = r_i; L = l_i; drxn = d_i; in_valid = 1'b1;
    e.res = eb;
    e.err = ee;
    e.lat = (ee || va == 5'd0) ? 0 : int'(va);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    b = $urandom; amt = 5'($urandom); A = 1'b1; R = 1'b1; L = 1'b0; drxn = ~d_i;
  endtask

  // Called right after the accepting edge; optionally stalls the result in DONE.
  task automatic collect(input int hold);
    exp_t e;
    int   lat;
    out_ready = (hold == 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check("out_valid_seen", {63'd0, out_valid}, 64'd1);
      check("latency", 64'(lat), 64'(e.lat));
      check("result_B", {32'd0, B}, {32'd0, e.res});
      check("err", {63'd0, err}, {63'd0, e.err});
      check("busy_in_done", {63'd0, busy}, 64'd1);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("stall_B", {32'd0, B}, {32'd0, e.res});
        check("stall_out_valid", {63'd0, out_valid}, 64'd1);
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_out_valid", {63'd0, out_valid}, 64'd0);
      check("release_in_ready", {63'd0, in_ready}, 64'd1);
      check("release_B_kept", {32'd0, B}, {32'd0, e.res});
    end
  endtask

  initial begin
    logic [31:0] rb;
    logic [4:0]  ra;
    logic [1:0]  rm;
    logic        rd;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_B", {32'd0, B}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Arithmetic, logical and rotate directed cases.
    send(32'hFFFFA780, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFA78, 1'b0); collect(0);
    send(32'hFFFFA780, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0FFFFA78, 1'b0); collect(0);
    send(32'hFFFFA780, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFA78000, 1'b0); collect(0);
    send(32'hFFFFA780, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFA78000, 1'b0); collect(0);
    send(32'hFFFFA780, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0FFFFA78, 1'b0); collect(0);
    send(32'hFFFFA780, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7FFFD3C0, 1'b0); collect(0);
    send(32'hFFFFA780, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFA780, 1'b0); collect(0);

    // Bad mode: no shifting, immediate DONE with err.
    send(32'h12345678, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1); collect(0);
    send(32'h12345678, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1); collect(0);

    // Backpressure with a competing request presented while busy.
    send(32'h80000001, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h30000000, 1'b0);
    b = 32'hDEADBEEF; amt = 5'd1; A = 1'b0; R = 1'b0; L = 1'b1; drxn = 1'b0; in_valid = 1'b1;
    collect(5);
    repeat (2) @(posedge clk);
    #1;
    check("no_stray_output", {63'd0, out_valid}, 64'd0);
    check("no_stray_busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of a shift with cnt==2.
    send(32'hF0000000, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFF000000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    void'(sb_q.pop_front());
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_B", {32'd0, B}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    send(32'h0000A5A5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0014B4A0, 1'b0); collect(0);

    // Random legal requests against the whole-amount model.
    for (int i = 0; i < 6; i++) begin
      rb = $urandom;
      ra = 5'($urandom);
      rm = 2'($urandom_range(0, 2));
      rd = 1'($urandom);
      send(rb, ra, rm == 2'd0, rm == 2'd1, rm == 2'd2, rd,
           model(rb, ra, rm == 2'd0, rm == 2'd1, rd), 1'b0);
      collect(int'($urandom_range(0, 2)));
    end

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
